swerv_axi_ram: RTL and testbench
================================

# swerv_axi_ram

AXI4 slave responder with an internal 64-bit-wide RAM, the far end of the core's IFU/LSU/SB AXI master ports. Accepts single-beat and INCR/FIXED bursts on independent read and write channels, echoes IDs, and returns OKAY or SLVERR. Serves as boot/data memory behind the core in simulation and small FPGA builds.

## Interface
- ID_WIDTH, 4: AXI ID width; matches the attached master's bus tag width.
- DEPTH, 1024: RAM depth in 64-bit words; power of two. Byte address width AW = log2(DEPTH)+3.
- clk  in  1  core clock; all logic on the rising edge.
- rst_l  in  1  asynchronous active-low reset.
- awvalid/awready  in/out  1  write-address handshake.
- awid  in  ID_WIDTH; awaddr  in  32; awlen  in  8; awsize  in  3; awburst  in  2.
- wvalid/wready  in/out  1; wdata  in  64; wstrb  in  8; wlast  in  1.
- bvalid/bready  out/in  1; bresp  out  2; bid  out  ID_WIDTH.
- arvalid/arready  in/out  1; arid  in  ID_WIDTH; araddr  in  32; arlen  in  8; arsize  in  3; arburst  in  2.
- rvalid/rready  out/in  1; rid  out  ID_WIDTH; rdata  out  64; rresp  out  2; rlast  out  1.

## Operation
- Reset: awready=1, arready=1; wready, bvalid, rvalid, rlast = 0; bresp, rresp, bid, rid, rdata = 0. RAM contents not reset.
- Write FSM, W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: awready=1; AW handshake latches id, addr, len, size, burst; go to W_DATA.
  - W_DATA: wready=1; each W handshake writes the strobed bytes of word addr[AW-1:3] when the beat is legal.
  - Beat counter increments per beat; leave on the beat with wlast=1.
  - Beat count is awlen+1. A wlast mismatch is ignored; wlast terminates the burst.
  - W_RESP: bvalid=1 with bid = latched id; hold until bready; then W_IDLE.
- Read FSM, R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: arready=1; AR handshake latches fields.
  - R_DATA: issues RAM reads into a 2-entry output buffer.
  - rlast=1 on beat arlen+1; R_IDLE after that beat's handshake.
- Address update per beat:
  - INCR: addr += 1<<size (size ≤ 3).
  - FIXED: addr unchanged.
- Error, resp=2'b10 SLVERR:
  - Triggers: burst=WRAP/reserved, size>3, or beat address ≥ DEPTH*8.
  - Errored write beats do not modify RAM; errored read beats return rdata=0.
  - One SLVERR beat makes bresp SLVERR for the whole write burst; rresp is per beat.
- Read and write channels are fully independent. A same-cycle read and write to one word returns the old data.
- rvalid/bvalid, once asserted, hold with stable payload until the handshake.

## Timing
- AW handshake at cycle N -> wready=1 from N+1. The write commits in the W handshake cycle and is visible to a read issued the next cycle.
- Last W handshake at M -> bvalid at M+1.
- AR handshake at N -> first rvalid at N+2. With rready held high, one beat per cycle; a 256-beat burst ends at N+257.
- rready low: buffer fills, reads stall, no beat lost or duplicated.
- Next AR accepted in the cycle after the rlast handshake; next AW accepted in the cycle after the B handshake.
- Reset asserted mid-burst: both FSMs return to idle, outputs go to reset values, the partial burst is abandoned.

## Configuration
- RV_AXI_RAM_RANDSTALL_EN defined:
  - A 16-bit LFSR (seed 16'hACE1, taps 16,14,13,11) advances each cycle.
  - awready, wready and arready are additionally gated by lfsr[0].
  - A new rvalid/bvalid assertion is delayed while lfsr[1]=0; an already-asserted valid is never withdrawn.
- Undefined: no LFSR; readies and valids as in Timing.

## Test plan
- Single write to 0x10, wdata 64'h1122334455667788, wstrb 8'h0F; read 0x10 -> rdata 64'h0000000055667788 (RAM preloaded 0), rresp 0, rlast 1, rid = arid.
- INCR write, awlen 3, size 3, addr 0x100, data 1..4; INCR read of the same range -> 4 back-to-back beats 1..4, first at AR+2, rlast only on beat 4, bresp 0.
- Read of 4 beats at 0x1FF8 (DEPTH 1024) -> beat 0 OKAY with data, beats 1-3 SLVERR with rdata 0.
- Write with awburst 2'b10 -> RAM unchanged, bresp 2'b10, bid echoed.
- rready toggling 1-of-3 cycles during a 16-beat read -> all 16 beats delivered in order, payload stable while stalled.
- Reset pulsed during beat 2 of a 4-beat write -> bvalid 0, awready 1 after reset; beats 0-1 retained, 2-3 not written.

Source files
------------

// File: rtl/swerv_axi_ram.sv
// swerv_axi_ram: AXI4 slave with a 64-bit internal RAM and independent read/write channels.
// Optional random handshake stalls are enabled by defining RV_AXI_RAM_RANDSTALL_EN.
module swerv_axi_ram #(
    parameter int ID_WIDTH = 4,
    parameter int DEPTH    = 1024
) (
    input  logic                clk,
    input  logic                rst_l,
    input  logic                awvalid,
    output logic                awready,
    input  logic [ID_WIDTH-1:0] awid,
    input  logic [31:0]         awaddr,
    input  logic [7:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic                wvalid,
    output logic                wready,
    input  logic [63:0]         wdata,
    input  logic [7:0]          wstrb,
    input  logic                wlast,
    output logic                bvalid,
    input  logic                bready,
    output logic [1:0]          bresp,
    output logic [ID_WIDTH-1:0] bid,
    input  logic                arvalid,
    output logic                arready,
    input  logic [ID_WIDTH-1:0] arid,
    input  logic [31:0]         araddr,
    input  logic [7:0]          arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    output logic                rvalid,
    input  logic                rready,
    output logic [ID_WIDTH-1:0] rid,
    output logic [63:0]         rdata,
    output logic [1:0]          rresp,
    output logic                rlast
);
    localparam int AW = $clog2(DEPTH) + 3;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

    function automatic logic beat_err(input logic [31:0] addr, input logic [2:0] size,
                                      input logic [1:0] burst);
        beat_err = burst[1] || (size > 3'd3) || (addr >= 32'(DEPTH * 8));
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [2:0] size,
                                              input logic [1:0] burst);
        next_addr = (burst == 2'b01) ? addr + (32'd1 << size) : addr;
    endfunction

    logic [63:0] mem_r [DEPTH];
    logic        ready_ok_s;
    logic        valid_ok_s;

`ifdef RV_AXI_RAM_RANDSTALL_EN
    logic [15:0] lfsr_r;

    // Free-running stall LFSR, x^16 + x^14 + x^13 + x^11 + 1
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            lfsr_r <= 16'hACE1;
        end else begin
            lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
        end
    end
    assign ready_ok_s = lfsr_r[0];
    assign valid_ok_s = lfsr_r[1];
`else
    assign ready_ok_s = 1'b1;
    assign valid_ok_s = 1'b1;
`endif

    // ---------------- write channel ----------------
    w_state_e            w_state_r;
    logic                awready_r, wready_r, bvalid_r, werr_r;
    logic [1:0]          bresp_r, wburst_r;
    logic [2:0]          wsize_r;
    logic [31:0]         waddr_r;
    logic [ID_WIDTH-1:0] bid_r, wid_r;
    logic                aw_hs_s, w_hs_s, b_hs_s, w_err_s;
    logic                awlen_unused_s;

    // wlast alone terminates a write burst, so the announced length is not needed
    assign awlen_unused_s = ^awlen;

    assign awready = awready_r & ready_ok_s;
    assign wready  = wready_r & ready_ok_s;
    assign bvalid  = bvalid_r;
    assign bresp   = bresp_r;
    assign bid     = bid_r;
    assign aw_hs_s = awvalid & awready;
    assign w_hs_s  = wvalid & wready;
    assign b_hs_s  = bvalid_r & bready;
    assign w_err_s = beat_err(waddr_r, wsize_r, wburst_r);

    // Write FSM: address latch, data beats, response
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            w_state_r <= W_IDLE;
            awready_r <= 1'b1;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            bresp_r   <= 2'b00;
            bid_r     <= '0;
            wid_r     <= '0;
            waddr_r   <= 32'd0;
            wsize_r   <= 3'd0;
            wburst_r  <= 2'b00;
            werr_r    <= 1'b0;
        end else begin
            case (w_state_r)
                W_IDLE: begin
                    if (aw_hs_s) begin
                        wid_r     <= awid;
                        waddr_r   <= awaddr;
                        wsize_r   <= awsize;
                        wburst_r  <= awburst;
                        werr_r    <= 1'b0;
                        awready_r <= 1'b0;
                        wready_r  <= 1'b1;
                        w_state_r <= W_DATA;
                    end else begin
                        w_state_r <= W_IDLE;
                    end
                end
                W_DATA: begin
                    if (w_hs_s) begin
                        waddr_r <= next_addr(waddr_r, wsize_r, wburst_r);
                        werr_r  <= werr_r | w_err_s;
                        if (wlast) begin
                            wready_r  <= 1'b0;
                            bresp_r   <= (werr_r | w_err_s) ? 2'b10 : 2'b00;
                            bid_r     <= wid_r;
                            bvalid_r  <= valid_ok_s;
                            w_state_r <= W_RESP;
                        end else begin
                            w_state_r <= W_DATA;
                        end
                    end else begin
                        w_state_r <= W_DATA;
                    end
                end
                W_RESP: begin
                    if (!bvalid_r) begin
                        bvalid_r <= valid_ok_s;
                    end else if (b_hs_s) begin
                        bvalid_r  <= 1'b0;
                        awready_r <= 1'b1;
                        w_state_r <= W_IDLE;
                    end else begin
                        w_state_r <= W_RESP;
                    end
                end
                default: begin
                    w_state_r <= W_IDLE;
                end
            endcase
        end
    end

    // RAM write port with byte strobes; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (w_hs_s && !w_err_s) begin
            for (int b = 0; b < 8; b++) begin
                if (wstrb[b]) begin
                    mem_r[waddr_r[AW-1:3]][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // ---------------- read channel ----------------
    r_state_e            r_state_r;
    logic                arready_r, rvalid_r, rlast_r, rdone_r;
    logic [63:0]         rdata_r, sk_data_r;
    logic [1:0]          rresp_r, sk_resp_r, rburst_r;
    logic                sk_valid_r, sk_last_r;
    logic [2:0]          rsize_r;
    logic [7:0]          rlen_r, rcnt_r;
    logic [31:0]         raddr_r;
    logic [ID_WIDTH-1:0] rid_r;
    logic                ar_hs_s, r_pop_s, r_err_s, r_issue_s, new_last_s;
    logic [63:0]         new_data_s;
    logic [1:0]          new_resp_s;

    assign arready    = arready_r & ready_ok_s;
    assign rvalid     = rvalid_r;
    assign rid        = rid_r;
    assign rdata      = rdata_r;
    assign rresp      = rresp_r;
    assign rlast      = rlast_r;
    assign ar_hs_s    = arvalid & arready;
    assign r_pop_s    = rvalid_r & rready;
    assign r_err_s    = beat_err(raddr_r, rsize_r, rburst_r);
    assign new_data_s = r_err_s ? 64'd0 : mem_r[raddr_r[AW-1:3]];
    assign new_resp_s = r_err_s ? 2'b10 : 2'b00;
    assign new_last_s = (rcnt_r == rlen_r);
    // Issue a RAM read only if the two-entry buffer (output reg + skid) has room after this cycle
    assign r_issue_s  = (r_state_r == R_DATA) && !rdone_r && !(rvalid_r && sk_valid_r && !r_pop_s)
                        && (rvalid_r || valid_ok_s);

    // Read FSM with address generation and the output/skid buffer
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state_r  <= R_IDLE;
            arready_r  <= 1'b1;
            rvalid_r   <= 1'b0;
            rdata_r    <= 64'd0;
            rresp_r    <= 2'b00;
            rlast_r    <= 1'b0;
            rid_r      <= '0;
            sk_valid_r <= 1'b0;
            sk_data_r  <= 64'd0;
            sk_resp_r  <= 2'b00;
            sk_last_r  <= 1'b0;
            raddr_r    <= 32'd0;
            rsize_r    <= 3'd0;
            rburst_r   <= 2'b00;
            rlen_r     <= 8'd0;
            rcnt_r     <= 8'd0;
            rdone_r    <= 1'b0;
        end else begin
            case (r_state_r)
                R_IDLE: begin
                    if (ar_hs_s) begin
                        rid_r     <= arid;
                        raddr_r   <= araddr;
                        rsize_r   <= arsize;
                        rburst_r  <= arburst;
                        rlen_r    <= arlen;
                        rcnt_r    <= 8'd0;
                        rdone_r   <= 1'b0;
                        arready_r <= 1'b0;
                        r_state_r <= R_DATA;
                    end else begin
                        r_state_r <= R_IDLE;
                    end
                end
                R_DATA: begin
                    if (r_issue_s) begin
                        raddr_r <= next_addr(raddr_r, rsize_r, rburst_r);
                        rcnt_r  <= rcnt_r + 8'd1;
                        rdone_r <= rdone_r | new_last_s;
                    end else begin
                        rcnt_r <= rcnt_r;
                    end
                    if (rvalid_r && !r_pop_s) begin
                        if (r_issue_s) begin
                            sk_valid_r <= 1'b1;
                            sk_data_r  <= new_data_s;
                            sk_resp_r  <= new_resp_s;
                            sk_last_r  <= new_last_s;
                        end else begin
                            sk_valid_r <= sk_valid_r;
                        end
                    end else if (sk_valid_r) begin
                        rvalid_r   <= 1'b1;
                        rdata_r    <= sk_data_r;
                        rresp_r    <= sk_resp_r;
                        rlast_r    <= sk_last_r;
                        sk_valid_r <= r_issue_s;
                        sk_data_r  <= new_data_s;
                        sk_resp_r  <= new_resp_s;
                        sk_last_r  <= new_last_s;
                    end else if (r_issue_s) begin
                        rvalid_r <= 1'b1;
                        rdata_r  <= new_data_s;
                        rresp_r  <= new_resp_s;
                        rlast_r  <= new_last_s;
                    end else begin
                        rvalid_r <= 1'b0;
                    end
                    if (r_pop_s && rlast_r) begin
                        arready_r <= 1'b1;
                        r_state_r <= R_IDLE;
                    end else begin
                        r_state_r <= R_DATA;
                    end
                end
                default: begin
                    r_state_r <= R_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_swerv_axi_ram.sv
// Directed self-checking bench for swerv_axi_ram (default build, DEPTH 1024).
module tb_swerv_axi_ram;
    logic        clk = 1'b0;
    logic        rst_l;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [3:0]  awid, bid, arid, rid;
    logic [31:0] awaddr, araddr;
    logic [7:0]  awlen, arlen, wstrb;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [63:0] wdata, rdata;
    logic        arvalid, arready, rvalid, rready, rlast;

    int tests = 0;
    int fails = 0;
    int to_cnt = 0;

    logic [63:0] wbuf [16];
    logic [63:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    logic [3:0]  rd_id [16];
    int          rd_cyc [16];
    int          got, first_idx, stall_bad;
    logic        ar_after, bv_now, aw_after;
    logic [1:0]  b_resp;
    logic [3:0]  b_id;

    swerv_axi_ram #(.ID_WIDTH(4), .DEPTH(1024)) dut (
        .clk(clk), .rst_l(rst_l),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
        .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr_burst(input logic [31:0] a, input logic [7:0] l, input logic [1:0] bu,
                            input logic [3:0] id, input logic [7:0] st);
        int n;
        @(negedge clk);
        awaddr = a; awlen = l; awsize = 3'd3; awburst = bu; awid = id; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 100) begin @(negedge clk); n++; end
        if (!awready) to_cnt++;
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i <= int'(l); i++) begin
            wdata = wbuf[i]; wstrb = st; wlast = (i == int'(l)); wvalid = 1'b1;
            n = 0;
            while (!wready && n < 100) begin @(negedge clk); n++; end
            if (!wready) to_cnt++;
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        bv_now = bvalid;
        bready = 1'b1;
        n = 0;
        while (!bvalid && n < 100) begin @(negedge clk); n++; end
        if (!bvalid) to_cnt++;
        b_resp = bresp; b_id = bid;
        @(negedge clk);
        bready = 1'b0;
        aw_after = awready;
    endtask

    task automatic rd_burst(input logic [31:0] a, input logic [7:0] l, input logic [1:0] bu,
                            input logic [3:0] id, input bit toggle);
        int n, cyc;
        bit prev_stall;
        logic [63:0] sv_data;
        logic [1:0]  sv_resp;
        logic        sv_last;
        @(negedge clk);
        araddr = a; arlen = l; arsize = 3'd3; arburst = bu; arid = id; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 100) begin @(negedge clk); n++; end
        if (!arready) to_cnt++;
        @(negedge clk);
        arvalid = 1'b0;
        got = 0; first_idx = -1; stall_bad = 0; prev_stall = 1'b0; cyc = 1;
        sv_data = 64'd0; sv_resp = 2'b00; sv_last = 1'b0;
        while (got <= int'(l) && cyc < 2000) begin
            rready = (toggle && (cyc % 3 != 0)) ? 1'b0 : 1'b1;
            if (prev_stall && !(rvalid === 1'b1 && rdata === sv_data && rresp === sv_resp
                                && rlast === sv_last)) stall_bad++;
            prev_stall = 1'b0;
            if (rvalid) begin
                if (first_idx < 0) first_idx = cyc;
                if (rready) begin
                    if (got < 16) begin
                        rd_data[got] = rdata; rd_resp[got] = rresp; rd_last[got] = rlast;
                        rd_id[got] = rid; rd_cyc[got] = cyc;
                    end
                    got++;
                end else begin
                    prev_stall = 1'b1;
                    sv_data = rdata; sv_resp = rresp; sv_last = rlast;
                end
            end
            @(negedge clk);
            cyc++;
        end
        rready = 1'b0;
        if (got <= int'(l)) to_cnt++;
        ar_after = arready;
    endtask

    initial begin
        int n;
        rst_l = 1'b0;
        awvalid = 1'b0; awid = 4'd0; awaddr = 32'd0; awlen = 8'd0; awsize = 3'd0; awburst = 2'b00;
        wvalid = 1'b0; wdata = 64'd0; wstrb = 8'd0; wlast = 1'b0; bready = 1'b0;
        arvalid = 1'b0; arid = 4'd0; araddr = 32'd0; arlen = 8'd0; arsize = 3'd0; arburst = 2'b00;
        rready = 1'b0;
        repeat (3) @(negedge clk);
        rst_l = 1'b1;
        @(negedge clk);

        // reset state
        chk("rst_awready", 64'(awready), 64'd1);
        chk("rst_arready", 64'(arready), 64'd1);
        chk("rst_wready", 64'(wready), 64'd0);
        chk("rst_bvalid", 64'(bvalid), 64'd0);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_rlast", 64'(rlast), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_bresp_bid", 64'({bresp, bid, rresp, rid}), 64'd0);

        // single strobed write over a zeroed word
        wbuf[0] = 64'd0;
        wr_burst(32'h10, 8'd0, 2'b01, 4'd3, 8'hFF);
        wbuf[0] = 64'h1122334455667788;
        wr_burst(32'h10, 8'd0, 2'b01, 4'd3, 8'h0F);
        chk("single_bvalid_m1", 64'(bv_now), 64'd1);
        chk("single_bresp", 64'(b_resp), 64'd0);
        chk("single_bid", 64'(b_id), 64'd3);
        chk("single_aw_after_b", 64'(aw_after), 64'd1);
        rd_burst(32'h10, 8'd0, 2'b01, 4'd5, 1'b0);
        chk("single_rdata", rd_data[0], 64'h0000000055667788);
        chk("single_rresp", 64'(rd_resp[0]), 64'd0);
        chk("single_rlast", 64'(rd_last[0]), 64'd1);
        chk("single_rid", 64'(rd_id[0]), 64'd5);
        chk("single_first_lat", 64'(first_idx), 64'd2);

        // INCR 4-beat write and read
        for (int i = 0; i < 4; i++) wbuf[i] = 64'(i + 1);
        wr_burst(32'h100, 8'd3, 2'b01, 4'd1, 8'hFF);
        chk("incr_bresp", 64'(b_resp), 64'd0);
        chk("incr_bid", 64'(b_id), 64'd1);
        rd_burst(32'h100, 8'd3, 2'b01, 4'd2, 1'b0);
        chk("incr_beats", 64'(got), 64'd4);
        chk("incr_first_lat", 64'(first_idx), 64'd2);
        chk("incr_back_to_back", 64'(rd_cyc[3] - rd_cyc[0]), 64'd3);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("incr_data%0d", i), rd_data[i], 64'(i + 1));
            chk($sformatf("incr_last%0d", i), 64'(rd_last[i]), (i == 3) ? 64'd1 : 64'd0);
        end
        chk("incr_ar_after_rlast", 64'(ar_after), 64'd1);

        // read crossing the end of the RAM
        wbuf[0] = 64'hCAFEF00DDEADBEEF;
        wr_burst(32'h1FF8, 8'd0, 2'b01, 4'd0, 8'hFF);
        rd_burst(32'h1FF8, 8'd3, 2'b01, 4'd7, 1'b0);
        chk("oob_data0", rd_data[0], 64'hCAFEF00DDEADBEEF);
        chk("oob_resp0", 64'(rd_resp[0]), 64'd0);
        for (int i = 1; i < 4; i++) begin
            chk($sformatf("oob_resp%0d", i), 64'(rd_resp[i]), 64'd2);
            chk($sformatf("oob_data%0d", i), rd_data[i], 64'd0);
        end

        // WRAP burst write is rejected
        wbuf[0] = 64'hA5A5A5A5A5A5A5A5;
        wr_burst(32'h300, 8'd0, 2'b01, 4'd0, 8'hFF);
        wbuf[0] = 64'hFFFFFFFFFFFFFFFF;
        wr_burst(32'h300, 8'd0, 2'b10, 4'hB, 8'hFF);
        chk("wrap_bresp", 64'(b_resp), 64'd2);
        chk("wrap_bid", 64'(b_id), 64'hB);
        rd_burst(32'h300, 8'd0, 2'b01, 4'd1, 1'b0);
        chk("wrap_ram_unchanged", rd_data[0], 64'hA5A5A5A5A5A5A5A5);

        // 16-beat read with rready high one cycle in three
        for (int i = 0; i < 16; i++) wbuf[i] = 64'h0101010101010101 * 64'(i + 1);
        wr_burst(32'h400, 8'd15, 2'b01, 4'd4, 8'hFF);
        rd_burst(32'h400, 8'd15, 2'b01, 4'd9, 1'b1);
        chk("stall_beats", 64'(got), 64'd16);
        chk("stall_stable", 64'(stall_bad), 64'd0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("stall_data%0d", i), rd_data[i], 64'h0101010101010101 * 64'(i + 1));
        end
        chk("stall_last15", 64'(rd_last[15]), 64'd1);
        chk("stall_last14", 64'(rd_last[14]), 64'd0);

        // reset during beat 2 of a 4-beat write
        for (int i = 0; i < 4; i++) wbuf[i] = 64'h5555555555555555;
        wr_burst(32'h200, 8'd3, 2'b01, 4'd0, 8'hFF);
        @(negedge clk);
        awaddr = 32'h200; awlen = 8'd3; awsize = 3'd3; awburst = 2'b01; awid = 4'd6; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 100) begin @(negedge clk); n++; end
        if (!awready) to_cnt++;
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wdata = 64'(16 + i); wstrb = 8'hFF; wlast = 1'b0; wvalid = 1'b1;
            n = 0;
            while (!wready && n < 100) begin @(negedge clk); n++; end
            if (!wready) to_cnt++;
            @(negedge clk);
        end
        wdata = 64'd18; wvalid = 1'b1;
        rst_l = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_l = 1'b1; wvalid = 1'b0;
        @(negedge clk);
        chk("mrst_bvalid", 64'(bvalid), 64'd0);
        chk("mrst_awready", 64'(awready), 64'd1);
        chk("mrst_wready", 64'(wready), 64'd0);
        rd_burst(32'h200, 8'd3, 2'b01, 4'd2, 1'b0);
        chk("mrst_beat0", rd_data[0], 64'd16);
        chk("mrst_beat1", rd_data[1], 64'd17);
        chk("mrst_beat2", rd_data[2], 64'h5555555555555555);
        chk("mrst_beat3", rd_data[3], 64'h5555555555555555);

        chk("handshake_timeouts", 64'(to_cnt), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
